// File: rtl/l15_req_arbiter_if.sv
// Request-side bundle between the cache requesters and the L1.5 arbiter.
// The slave modport is the arbiter's view; the master modport is the requester/L1.5 side.
interface l15_req_arbiter_if #(
    parameter int NR_REQ    = 3,
    parameter int PAYLOAD_W = 128,
    parameter int SRC_W     = (NR_REQ > 1) ? $clog2(NR_REQ) : 1
);
    logic [NR_REQ-1:0]           req_valid_i;
    logic [NR_REQ-1:0]           req_ready_o;
    logic [NR_REQ-1:0]           req_store_i;
    logic [NR_REQ*PAYLOAD_W-1:0] req_payload_i;
    logic                        l15_valid_o;
    logic                        l15_ready_i;
    logic [PAYLOAD_W-1:0]        l15_payload_o;
    logic [SRC_W-1:0]            l15_src_o;
    logic                        l15_store_o;
    logic                        store_ack_i;
    logic [3:0]                  stores_out_o;
    logic                        ack_err_o;

    modport master (
        output req_valid_i, req_store_i, req_payload_i, l15_ready_i, store_ack_i,
        input  req_ready_o, l15_valid_o, l15_payload_o, l15_src_o, l15_store_o,
               stores_out_o, ack_err_o
    );

    modport slave (
        input  req_valid_i, req_store_i, req_payload_i, l15_ready_i, store_ack_i,
        output req_ready_o, l15_valid_o, l15_payload_o, l15_src_o, l15_store_o,
               stores_out_o, ack_err_o
    );
endinterface

// File: rtl/l15_req_arbiter.sv
// Arbitrates NR_REQ cache requesters into a one-entry L1.5 request slot with outstanding-store throttling.
// Define L15_ARB_FIXED_PRIO_EN for fixed lowest-index priority; default build is round-robin.
module l15_req_arbiter #(
    parameter int NR_REQ         = 3,
    parameter int PAYLOAD_W      = 128,
    parameter int MAX_OUT_STORES = 7
) (
    input logic              clk_i,
    input logic              rst_i,
    l15_req_arbiter_if.slave bus
);
    localparam int SRC_W = (NR_REQ > 1) ? $clog2(NR_REQ) : 1;

    logic [NR_REQ-1:0]    eligible;
    logic                 slot_free;
    logic                 ack_valid;
    logic                 budget_ok;
    logic                 grant;
    logic                 win_store;
    logic [3:0]           stores_after_ack;
    logic [SRC_W-1:0]     winner;
    logic [PAYLOAD_W-1:0] win_payload;

    logic                 slot_valid;
    logic                 slot_store;
    logic [PAYLOAD_W-1:0] slot_payload;
    logic [SRC_W-1:0]     slot_src;
    logic [3:0]           stores_out;
    logic                 ack_err;

    // An ack arriving at the limit frees budget for a store granted in the same cycle.
    assign slot_free        = !slot_valid || bus.l15_ready_i;
    assign ack_valid        = bus.store_ack_i && (stores_out != 4'd0);
    assign stores_after_ack = stores_out - {3'b000, ack_valid};
    assign budget_ok        = stores_after_ack < 4'(MAX_OUT_STORES);
    assign eligible         = bus.req_valid_i & (~bus.req_store_i | {NR_REQ{budget_ok}});
    assign grant            = !rst_i && slot_free && (|eligible);

`ifdef L15_ARB_FIXED_PRIO_EN
    always_comb begin
        winner = '0;
        for (int j = NR_REQ - 1; j >= 0; j--) begin
            if (eligible[j]) winner = SRC_W'(j);
        end
    end
`else
    logic [SRC_W-1:0] rr_ptr;
    logic             found;

    // Two passes: indices above the last winner first, then wrap to the rest.
    always_comb begin
        winner = '0;
        found  = 1'b0;
        for (int j = 0; j < NR_REQ; j++) begin
            if (!found && eligible[j] && (SRC_W'(j) > rr_ptr)) begin
                found  = 1'b1;
                winner = SRC_W'(j);
            end
        end
        for (int j = 0; j < NR_REQ; j++) begin
            if (!found && eligible[j] && (SRC_W'(j) <= rr_ptr)) begin
                found  = 1'b1;
                winner = SRC_W'(j);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rr_ptr <= SRC_W'(NR_REQ - 1);
        end else if (grant) begin
            rr_ptr <= winner;
        end
    end
`endif

    always_comb begin
        win_payload     = '0;
        win_store       = 1'b0;
        bus.req_ready_o = '0;
        for (int j = 0; j < NR_REQ; j++) begin
            if (winner == SRC_W'(j)) begin
                win_payload        = bus.req_payload_i[j*PAYLOAD_W +: PAYLOAD_W];
                win_store          = bus.req_store_i[j];
                bus.req_ready_o[j] = grant;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            slot_valid   <= 1'b0;
            slot_store   <= 1'b0;
            slot_payload <= '0;
            slot_src     <= '0;
            stores_out   <= 4'd0;
            ack_err      <= 1'b0;
        end else begin
            if (grant) begin
                slot_valid   <= 1'b1;
                slot_payload <= win_payload;
                slot_src     <= winner;
                slot_store   <= win_store;
            end else if (bus.l15_ready_i) begin
                slot_valid <= 1'b0;
            end
            stores_out <= stores_after_ack + {3'b000, grant && win_store};
            if (bus.store_ack_i && (stores_out == 4'd0)) begin
                ack_err <= 1'b1;
            end
        end
    end

    assign bus.l15_valid_o   = slot_valid;
    assign bus.l15_payload_o = slot_payload;
    assign bus.l15_src_o     = slot_src;
    assign bus.l15_store_o   = slot_store;
    assign bus.stores_out_o  = stores_out;
    assign bus.ack_err_o     = ack_err;
endmodule
